// File: rtl/sound_pkg.sv
// Shared event/state types and oscillator divider codes for the sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    EvNone = 2'd0,
    EvGood = 2'd1,
    EvBad  = 2'd2,
    EvMove = 2'd3
  } event_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam logic [7:0] DivGood = 8'd89;
  localparam logic [7:0] DivBad  = 8'd126;
  localparam logic [7:0] DivMove = 8'd149;

  // Divider code for an event; NONE maps to silence.
  function automatic logic [7:0] div_code(event_e ev);
    logic [7:0] code;
    code = 8'd0;
    case (ev)
      EvGood:  code = DivGood;
      EvBad:   code = DivBad;
      EvMove:  code = DivMove;
      default: code = 8'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sound_fifo.sv
// Circular event FIFO with synchronous flush; a flush may carry a push that lands in slot 0.
module sound_fifo
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   nRst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  event_e data_in,
  output event_e data_out,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] waddr;
  logic          do_push;
  logic          do_pop;
  event_e        mem_q [DEPTH];

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCount);
  assign data_out = mem_q[rptr_q];

  // Pointer and occupancy next-state; flush restarts the ring at slot 0.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    do_push = push && (flush || !full);
    do_pop  = pop && !empty && !flush;
    waddr   = flush ? '0 : wptr_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = do_push ? AW'(1) : '0;
      count_d = do_push ? (AW + 1)'(1) : '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[waddr] <= data_in;
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Queues game sound events and plays them one at a time as fixed-length tones
// separated by a silent gap; BAD pre-empts everything.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DUR_GOOD = 20,
  parameter int unsigned DUR_BAD  = 50,
  parameter int unsigned DUR_MOVE = 5,
  parameter int unsigned GAP      = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic       move_i,
  output logic [7:0] freq_o,
  output logic       playSound_o,
  output logic       busy_o,
  output logic       drop_o
);

  localparam int unsigned MaxA   = (DUR_GOOD > DUR_BAD) ? DUR_GOOD : DUR_BAD;
  localparam int unsigned MaxB   = (DUR_MOVE > GAP) ? DUR_MOVE : GAP;
  localparam int unsigned MaxDur = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxDur + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      freq_q, freq_d;
  logic            play_q, play_d;
  logic            drop_q, drop_d;

  event_e win;
  event_e fifo_out;
  logic   fifo_push, fifo_pop, fifo_flush;
  logic   fifo_empty, fifo_full;

  function automatic logic [CntW-1:0] dur_code(event_e ev);
    logic [CntW-1:0] d;
    d = '0;
    case (ev)
      EvGood:  d = CntW'(DUR_GOOD);
      EvBad:   d = CntW'(DUR_BAD);
      EvMove:  d = CntW'(DUR_MOVE);
      default: d = '0;
    endcase
    return d;
  endfunction

  sound_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nRst     (nRst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .data_in  (win),
    .data_out (fifo_out),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Pick the single winning event this cycle: BAD > GOOD > MOVE.
  always_comb begin
    win = EvNone;
    if (badColl_i)       win = EvBad;
    else if (goodColl_i) win = EvGood;
    else if (move_i)     win = EvMove;
  end

  // Queue admission and note-playing FSM next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freq_d     = freq_q;
    play_d     = play_q;
    drop_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (!enable_i) begin
      fifo_flush = 1'b1;
      state_d    = StIdle;
      cnt_d      = '0;
      freq_d     = 8'd0;
      play_d     = 1'b0;
    end else begin
      case (win)
        EvBad: begin
          fifo_flush = 1'b1;
          fifo_push  = 1'b1;
        end
        EvGood: begin
          if (fifo_full) drop_d = 1'b1;
          else           fifo_push = 1'b1;
        end
        EvMove: begin
          if (fifo_empty && (state_q == StIdle || state_q == StGap)) fifo_push = 1'b1;
        end
        default: ;
      endcase

      case (state_q)
        StIdle: begin
          // A same-edge BAD replaces the queue, so nothing is popped this edge.
          if (!fifo_empty && win != EvBad) begin
            fifo_pop = 1'b1;
            state_d  = StPlay;
            freq_d   = div_code(fifo_out);
            play_d   = 1'b1;
            cnt_d    = dur_code(fifo_out);
          end
        end
        StPlay: begin
          if (win == EvBad) begin
            state_d = StIdle;
            play_d  = 1'b0;
            freq_d  = 8'd0;
            cnt_d   = '0;
          end else if (cnt_q <= CntW'(1)) begin
            state_d = StGap;
            play_d  = 1'b0;
            freq_d  = 8'd0;
            cnt_d   = CntW'(GAP);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q <= CntW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          freq_d  = 8'd0;
          play_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM state, duration counter and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      freq_q  <= 8'd0;
      play_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      play_q  <= play_d;
      drop_q  <= drop_d;
    end
  end

  assign freq_o      = freq_q;
  assign playSound_o = play_q;
  assign drop_o      = drop_q;
  assign busy_o      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer with default parameters.
module tb_sound_event_sequencer;

  logic       clk;
  logic       nRst;
  logic       enable_i;
  logic       goodColl_i;
  logic       badColl_i;
  logic       move_i;
  logic [7:0] freq_o;
  logic       playSound_o;
  logic       busy_o;
  logic       drop_o;

  int checks;
  int failures;

  sound_event_sequencer dut (
    .clk         (clk),
    .nRst        (nRst),
    .enable_i    (enable_i),
    .goodColl_i  (goodColl_i),
    .badColl_i   (badColl_i),
    .move_i      (move_i),
    .freq_o      (freq_o),
    .playSound_o (playSound_o),
    .busy_o      (busy_o),
    .drop_o      (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    goodColl_i = 1'b0;
    badColl_i  = 1'b0;
    move_i     = 1'b0;
  endtask

  task automatic test_reset();
    nRst     = 1'b0;
    enable_i = 1'b1;
    clear_inputs();
    #12;
    checks++;
    if (playSound_o !== 1'b0 || freq_o !== 8'd0 || busy_o !== 1'b0 || drop_o !== 1'b0) begin
      failures++;
      $display("FAIL reset play=%0b freq=%0d busy=%0b drop=%0b required all 0",
               playSound_o, freq_o, busy_o, drop_o);
    end
    tick();
    nRst = 1'b1;
    tick();
    tick();
  endtask

  // Single GOOD: note at t=2..21, silence t=22..23, idle from t=24.
  task automatic test_single_good();
    logic       ep;
    logic [7:0] ef;
    goodColl_i = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      tick();
      clear_inputs();
      ep = (t >= 2 && t <= 21);
      ef = ep ? 8'd89 : 8'd0;
      checks++;
      if (playSound_o !== ep || freq_o !== ef) begin
        failures++;
        $display("FAIL single_good t=%0d play=%0b freq=%0d required play=%0b freq=%0d",
                 t, playSound_o, freq_o, ep, ef);
      end
      if (t == 23 || t == 24) begin
        checks++;
        if (busy_o !== (t == 23)) begin
          failures++;
          $display("FAIL single_good_busy t=%0d busy=%0b required %0b", t, busy_o, (t == 23));
        end
      end
    end
  endtask

  // Five GOODs during a note: four queue, fifth drops; five 20-cycle notes total.
  task automatic test_queue_drop();
    logic       ep;
    logic [7:0] ef;
    int         drops;
    drops = 0;
    goodColl_i = 1'b1;
    for (int t = 1; t <= 120; t++) begin
      tick();
      clear_inputs();
      goodColl_i = (t >= 3 && t <= 7);
      ep = (t >= 2 && t < 114 && ((t - 2) % 23) < 20);
      ef = ep ? 8'd89 : 8'd0;
      if (drop_o === 1'b1) drops++;
      checks++;
      if (playSound_o !== ep || freq_o !== ef) begin
        failures++;
        $display("FAIL queue_drop t=%0d play=%0b freq=%0d required play=%0b freq=%0d",
                 t, playSound_o, freq_o, ep, ef);
      end
      if (t == 8) begin
        checks++;
        if (drop_o !== 1'b1) begin
          failures++;
          $display("FAIL queue_drop_pulse t=%0d drop=%0b required 1", t, drop_o);
        end
      end
    end
    checks++;
    if (drops != 1) begin
      failures++;
      $display("FAIL queue_drop_count drops=%0d required 1", drops);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL queue_drop_idle busy=%0b required 0", busy_o);
    end
  endtask

  // BAD in the 5th cycle of a note with 2 GOODs queued.
  task automatic test_bad_preempt();
    logic       ep;
    logic [7:0] ef;
    goodColl_i = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      tick();
      clear_inputs();
      goodColl_i = (t == 3 || t == 4);
      badColl_i  = (t == 6);
      ep = (t >= 2 && t <= 6) || (t >= 8 && t <= 57);
      ef = !ep ? 8'd0 : (t <= 6) ? 8'd89 : 8'd126;
      checks++;
      if (playSound_o !== ep || freq_o !== ef) begin
        failures++;
        $display("FAIL bad_preempt t=%0d play=%0b freq=%0d required play=%0b freq=%0d",
                 t, playSound_o, freq_o, ep, ef);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL bad_preempt_idle busy=%0b required 0", busy_o);
    end
  endtask

  // GOOD, BAD and MOVE together: only a 50-cycle BAD note.
  task automatic test_simultaneous();
    logic       ep;
    logic [7:0] ef;
    goodColl_i = 1'b1;
    badColl_i  = 1'b1;
    move_i     = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      clear_inputs();
      ep = (t >= 2 && t <= 51);
      ef = ep ? 8'd126 : 8'd0;
      checks++;
      if (playSound_o !== ep || freq_o !== ef || drop_o !== 1'b0) begin
        failures++;
        $display("FAIL simultaneous t=%0d play=%0b freq=%0d drop=%0b required play=%0b freq=%0d drop=0",
                 t, playSound_o, freq_o, drop_o, ep, ef);
      end
    end
  endtask

  // MOVE from idle plays a 5-cycle 149 note; MOVE while busy is silently ignored.
  task automatic test_move();
    logic       ep;
    logic [7:0] ef;
    move_i = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      clear_inputs();
      ep = (t >= 2 && t <= 6);
      ef = ep ? 8'd149 : 8'd0;
      checks++;
      if (playSound_o !== ep || freq_o !== ef) begin
        failures++;
        $display("FAIL move_idle t=%0d play=%0b freq=%0d required play=%0b freq=%0d",
                 t, playSound_o, freq_o, ep, ef);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL move_idle_busy busy=%0b required 0", busy_o);
    end
    goodColl_i = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      clear_inputs();
      move_i = (t == 5);
      ep = (t >= 2 && t <= 21);
      ef = ep ? 8'd89 : 8'd0;
      checks++;
      if (playSound_o !== ep || freq_o !== ef || drop_o !== 1'b0) begin
        failures++;
        $display("FAIL move_busy t=%0d play=%0b freq=%0d drop=%0b required play=%0b freq=%0d drop=0",
                 t, playSound_o, freq_o, drop_o, ep, ef);
      end
    end
  endtask

  // After a disturbance, a fresh GOOD must start at k+2 and the block must go idle.
  task automatic check_fresh_good(input string name);
    goodColl_i = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (playSound_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_k1 play=%0b required 0", name, playSound_o);
    end
    tick();
    checks++;
    if (playSound_o !== 1'b1 || freq_o !== 8'd89) begin
      failures++;
      $display("FAIL %s_k2 play=%0b freq=%0d required play=1 freq=89", name, playSound_o, freq_o);
    end
    for (int i = 0; i < 24; i++) tick();
    checks++;
    if (busy_o !== 1'b0 || playSound_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_done busy=%0b play=%0b required 0 0", name, busy_o, playSound_o);
    end
  endtask

  // Reset mid-note with an event queued silences immediately and empties the FIFO.
  task automatic test_reset_mid_note();
    goodColl_i = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      clear_inputs();
      goodColl_i = (t == 3);
    end
    clear_inputs();
    checks++;
    if (playSound_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre play=%0b required 1", playSound_o);
    end
    nRst = 1'b0;
    #2;
    checks++;
    if (playSound_o !== 1'b0 || freq_o !== 8'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid play=%0b freq=%0d busy=%0b required 0 0 0",
               playSound_o, freq_o, busy_o);
    end
    tick();
    nRst = 1'b1;
    tick();
    check_fresh_good("reset_mid_good");
  endtask

  // enable_i low mid-note silences at the next edge, flushes, and ignores events.
  task automatic test_enable_mid_note();
    goodColl_i = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      clear_inputs();
      goodColl_i = (t == 3);
    end
    enable_i = 1'b0;
    checks++;
    if (playSound_o !== 1'b1) begin
      failures++;
      $display("FAIL enable_mid_pre play=%0b required 1", playSound_o);
    end
    tick();
    checks++;
    if (playSound_o !== 1'b0 || freq_o !== 8'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL enable_mid play=%0b freq=%0d busy=%0b required 0 0 0",
               playSound_o, freq_o, busy_o);
    end
    goodColl_i = 1'b1;
    badColl_i  = 1'b1;
    tick();
    clear_inputs();
    enable_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (playSound_o !== 1'b0 || busy_o !== 1'b0 || drop_o !== 1'b0) begin
        failures++;
        $display("FAIL enable_ignore t=%0d play=%0b busy=%0b drop=%0b required 0 0 0",
                 t, playSound_o, busy_o, drop_o);
      end
      tick();
    end
    check_fresh_good("enable_mid_good");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_good();
    test_queue_drop();
    test_bad_preempt();
    test_simultaneous();
    test_move();
    test_reset_mid_note();
    test_enable_mid_note();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout reached time=%0t required completion", $time);
    $fatal(1);
  end

endmodule
